// File: rtl/operand_extender_pipe.sv
// operand_extender_pipe
//   Pipelined operand extender on the multiplier input path. Widens IN_W-bit
//   operands to OUT_W bits with a per-transaction fill mode (zero, sign,
//   leading-one). It has a main output register plus one skid register,
//   valid/ready on both sides, and a latency of one cycle. It also keeps a
//   saturating count of transfers whose fill bits were set.
//
//   Ports:
//     clk, rst_n           clock, synchronous active-low reset
//     in_valid/in_ready    input handshake (in_ready registered: skid empty)
//     in_data, in_mode     operand; mode 00 ZERO, 01 SIGN, 10 LEAD1, 11 = ZERO
//     out_valid/out_ready  output handshake
//     out_data, out_ext    extended result; out_ext = any fill bit set
//     ext_cnt              saturating count of transfers with out_ext=1
//
//   Optional feature macro OPX_LZC_EN adds:
//     out_lead             index of the highest set bit of the held operand
//     out_zero             held operand was zero (out_lead is 0 in that case)
module operand_extender_pipe #(
    parameter int unsigned IN_W     = 16,
    parameter int unsigned OUT_W    = 32,
    parameter int unsigned LEAD_MIN = 7,
    parameter int unsigned CNT_W    = 16,
    localparam int unsigned LW      = (IN_W > 2) ? $clog2(IN_W) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ext,
`ifdef OPX_LZC_EN
    output logic [LW-1:0]    out_lead,
    output logic             out_zero,
`endif
    output logic [CNT_W-1:0] ext_cnt
);

    typedef enum logic [1:0] {
        MODE_ZERO  = 2'b00,
        MODE_SIGN  = 2'b01,
        MODE_LEAD1 = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    mode_e             mode;
    int unsigned       lead_idx;
    logic              nonzero;
    logic [OUT_W-1:0]  ext_data;
    logic              ext_flag;
    logic              accept;
    logic              xfer;

    logic              skid_valid;
    logic [OUT_W-1:0]  skid_data;
    logic              skid_ext;
`ifdef OPX_LZC_EN
    logic [LW-1:0]     skid_lead;
    logic              skid_zero;
`endif

    assign mode    = mode_e'(in_mode);
    assign nonzero = |in_data;
    assign accept  = in_valid && in_ready;
    assign xfer    = out_valid && out_ready;

    // Priority encoder: the last set bit seen while scanning upward wins.
    always_comb begin
        lead_idx = 0;
        for (int unsigned i = 0; i < IN_W; i++) begin
            if (in_data[i]) lead_idx = i;
        end
    end

    always_comb begin
        ext_data = {{(OUT_W-IN_W){1'b0}}, in_data};
        case (mode)
            MODE_SIGN: begin
                if (in_data[IN_W-1]) ext_data[OUT_W-1:IN_W] = '1;
            end
            MODE_LEAD1: begin
                // Fill from the leading one upward; bit p itself is already 1.
                if (nonzero && lead_idx >= LEAD_MIN) begin
                    for (int unsigned i = 0; i < OUT_W; i++) begin
                        if (i >= lead_idx) ext_data[i] = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign ext_flag = |ext_data[OUT_W-1:IN_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ext    <= 1'b0;
            ext_cnt    <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ext   <= 1'b0;
`ifdef OPX_LZC_EN
            out_lead   <= '0;
            out_zero   <= 1'b0;
            skid_lead  <= '0;
            skid_zero  <= 1'b0;
`endif
        end else begin
            in_ready <= 1'b1;
            if (xfer && out_ext && (ext_cnt != '1)) begin
                ext_cnt <= ext_cnt + CNT_W'(1);
            end

            if (skid_valid) begin
                // in_ready is low here, so only draining is possible.
                if (xfer) begin
                    out_data   <= skid_data;
                    out_ext    <= skid_ext;
`ifdef OPX_LZC_EN
                    out_lead   <= skid_lead;
                    out_zero   <= skid_zero;
`endif
                    skid_valid <= 1'b0;
                end else begin
                    in_ready   <= 1'b0;
                end
            end else if (accept) begin
                if (!out_valid || out_ready) begin
                    out_valid <= 1'b1;
                    out_data  <= ext_data;
                    out_ext   <= ext_flag;
`ifdef OPX_LZC_EN
                    out_lead  <= LW'(lead_idx);
                    out_zero  <= !nonzero;
`endif
                end else begin
                    skid_valid <= 1'b1;
                    skid_data  <= ext_data;
                    skid_ext   <= ext_flag;
`ifdef OPX_LZC_EN
                    skid_lead  <= LW'(lead_idx);
                    skid_zero  <= !nonzero;
`endif
                    in_ready   <= 1'b0;
                end
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
